// File: rtl/pwm_pkg.sv
// pwm_pkg: definitions shared across the PWM blocks.
//   - gate-driver FSM state encoding (also the drv_state readback value)
//   - default dead-time counter width
//   - CSR word offset holding the dead_time / dt_enable fields
package pwm_pkg;

    // Gate-driver FSM states
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] HIGH_ON = 2'd1;
    localparam logic [1:0] LOW_ON  = 2'd2;
    localparam logic [1:0] DEAD    = 2'd3;

    localparam int unsigned DT_WIDTH_DEF = 16;

    // CSR word holding dead_time[DT_WIDTH-1:0] and dt_enable, next to period/duty/prescaler
    localparam int unsigned CSR_ADDR_WIDTH      = 8;
    localparam logic [7:0]  CSR_DEADTIME_OFFSET = 8'h0C;

endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: turns the single-ended PWM core output into a complementary
// high-side / low-side gate pair, inserting a programmable dead time at every edge.
// Ports:
//   clk       - system clock, rising edge
//   reset     - synchronous active-low reset
//   enable    - gate-drive enable, 0 forces both gates inactive
//   pwm_in    - PWM core output (same clock domain)
//   dead_time - dead time in clk cycles, 0 = direct switch
//   pwm_h     - high-side drive (registered, active level H_ACTIVE)
//   pwm_l     - low-side drive (registered, active level L_ACTIVE)
//   dt_active - 1 while in DEAD (registered)
//   drv_state - current FSM state for status readback
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int unsigned DT_WIDTH = DT_WIDTH_DEF,
    parameter logic        H_ACTIVE = 1'b1,
    parameter logic        L_ACTIVE = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                pwm_in,
    input  logic [DT_WIDTH-1:0] dead_time,
    output logic                pwm_h,
    output logic                pwm_l,
    output logic                dt_active,
    output logic [1:0]          drv_state
);

    logic [1:0]          r_state;
    logic [DT_WIDTH-1:0] r_cnt;
    logic                r_target;
    logic                r_pwm_h;
    logic                r_pwm_l;
    logic                r_dt_active;

    logic [1:0]          w_state_nxt;
    logic [DT_WIDTH-1:0] w_cnt_nxt;
    logic                w_target_nxt;
    logic                w_load;
    logic                w_pwm_h_nxt;
    logic                w_pwm_l_nxt;
    logic                w_dt_active_nxt;

    // Next-state, counter and output decode
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_target_nxt    = r_target;
        w_load          = 1'b0;

        if (!enable) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_load = 1'b1;
                HIGH_ON: w_load = ~pwm_in;
                LOW_ON:  w_load = pwm_in;
                DEAD: begin
                    // A re-toggle restarts the full dead time, so short pulses are absorbed
                    if (pwm_in != r_target) begin
                        w_load = 1'b1;
                    end else if (r_cnt == '0) begin
                        w_state_nxt = r_target ? HIGH_ON : LOW_ON;
                    end else begin
                        w_cnt_nxt = r_cnt - DT_WIDTH'(1);
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end

        // Common load action: latch the new target, then either dead time or direct switch
        if (w_load) begin
            w_target_nxt = pwm_in;
            if (dead_time == '0) begin
                w_state_nxt = pwm_in ? HIGH_ON : LOW_ON;
            end else begin
                w_state_nxt = DEAD;
                w_cnt_nxt   = dead_time - DT_WIDTH'(1);
            end
        end

        // Outputs follow the next state so they change on the same edge as the state
        w_pwm_h_nxt     = (w_state_nxt == HIGH_ON) ? H_ACTIVE : ~H_ACTIVE;
        w_pwm_l_nxt     = (w_state_nxt == LOW_ON)  ? L_ACTIVE : ~L_ACTIVE;
        w_dt_active_nxt = (w_state_nxt == DEAD);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_target    <= 1'b0;
            r_pwm_h     <= ~H_ACTIVE;
            r_pwm_l     <= ~L_ACTIVE;
            r_dt_active <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_target    <= w_target_nxt;
            r_pwm_h     <= w_pwm_h_nxt;
            r_pwm_l     <= w_pwm_l_nxt;
            r_dt_active <= w_dt_active_nxt;
        end
    end

    assign pwm_h     = r_pwm_h;
    assign pwm_l     = r_pwm_l;
    assign dt_active = r_dt_active;
    assign drv_state = r_state;

endmodule

// File: tb/tb_pwm_deadtime.sv
// tb_pwm_deadtime: directed checks of pwm_deadtime with hand-computed expectations.
// Two instances share stimulus: active-high gates (u_dut) and active-low gates (u_dut_n).
module tb_pwm_deadtime;

    localparam int unsigned DTW = 16;

    // Expected {pwm_h, pwm_l, dt_active, drv_state} for the active-high instance
    localparam logic [4:0] E_IDLE = 5'b00_0_00;
    localparam logic [4:0] E_HIGH = 5'b10_0_01;
    localparam logic [4:0] E_LOW  = 5'b01_0_10;
    localparam logic [4:0] E_DEAD = 5'b00_1_11;

    logic           clk;
    logic           reset;
    logic           enable;
    logic           pwm_in;
    logic [DTW-1:0] dead_time;
    logic           pwm_h,   pwm_l,   dt_active;
    logic [1:0]     drv_state;
    logic           pwm_h_n, pwm_l_n, dt_active_n;
    logic [1:0]     drv_state_n;

    int n_vec;
    int n_err;
    int ov_pos;
    int ov_neg;
    int h_cnt;
    int l_cnt;

    pwm_deadtime #(.DT_WIDTH(DTW), .H_ACTIVE(1'b1), .L_ACTIVE(1'b1)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .pwm_in    (pwm_in),
        .dead_time (dead_time),
        .pwm_h     (pwm_h),
        .pwm_l     (pwm_l),
        .dt_active (dt_active),
        .drv_state (drv_state)
    );

    pwm_deadtime #(.DT_WIDTH(DTW), .H_ACTIVE(1'b0), .L_ACTIVE(1'b0)) u_dut_n (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .pwm_in    (pwm_in),
        .dead_time (dead_time),
        .pwm_h     (pwm_h_n),
        .pwm_l     (pwm_l_n),
        .dt_active (dt_active_n),
        .drv_state (drv_state_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count any cycle where both gates sit at their active level
    always @(negedge clk) begin
        if (pwm_h === 1'b1 && pwm_l === 1'b1)     ov_pos++;
        if (pwm_h_n === 1'b0 && pwm_l_n === 1'b0) ov_neg++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock, settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] obs();
        return 32'({pwm_h, pwm_l, dt_active, drv_state});
    endfunction

    initial begin
        n_vec = 0; n_err = 0; ov_pos = 0; ov_neg = 0;
        reset = 1'b0; enable = 1'b1; pwm_in = 1'b1; dead_time = 16'd4;

        // Reset held 3 cycles with enable and pwm_in high
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_obs", obs(), 32'(E_IDLE));
            chk("reset_neg_hl", 32'({pwm_h_n, pwm_l_n}), 32'd3);
        end

        // Startup: full 4-cycle dead time then high side
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("startup_dead", obs(), 32'(E_DEAD));
        end
        tick();
        chk("startup_high", obs(), 32'(E_HIGH));
        chk("neg_high_on", 32'({pwm_h_n, pwm_l_n}), 32'd1);

        // Steady PWM, 10 high / 10 low, dead_time=3
        dead_time = 16'd3;
        for (int p = 0; p < 4; p++) begin
            pwm_in = (p % 2 == 1);
            h_cnt = 0; l_cnt = 0;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (pwm_h) h_cnt++;
                if (pwm_l) l_cnt++;
                if (k < 3) chk("pwm_dead", obs(), 32'(E_DEAD));
                else       chk("pwm_on", obs(), pwm_in ? 32'(E_HIGH) : 32'(E_LOW));
            end
            chk("pwm_on_len", 32'(pwm_in ? h_cnt : l_cnt), 32'd7);
        end

        // dead_time=0: gates swap on the same edge, never DEAD
        dead_time = 16'd0;
        for (int i = 0; i < 6; i++) begin
            pwm_in = (i % 2 == 1);
            tick();
            chk("dt0_swap", obs(), pwm_in ? 32'(E_HIGH) : 32'(E_LOW));
        end

        // Glitch: fall then rise two cycles later, dead_time=5
        dead_time = 16'd5;
        pwm_in = 1'b0;
        tick(); chk("glitch_fall", obs(), 32'(E_DEAD));
        tick(); chk("glitch_mid", obs(), 32'(E_DEAD));
        pwm_in = 1'b1;
        tick(); chk("glitch_rise", obs(), 32'(E_DEAD));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("glitch_restart", obs(), 32'(E_DEAD));
        end
        tick(); chk("glitch_high", obs(), 32'(E_HIGH));

        // Enable dropped 3 cycles into an 8-cycle dead time
        dead_time = 16'd8;
        pwm_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("en_dead", obs(), 32'(E_DEAD));
        end
        enable = 1'b0;
        tick(); chk("en_off_idle", obs(), 32'(E_IDLE));
        tick(); chk("en_off_hold", obs(), 32'(E_IDLE));
        chk("en_off_neg_hl", 32'({pwm_h_n, pwm_l_n}), 32'd3);
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("en_on_dead", obs(), 32'(E_DEAD));
        end
        tick(); chk("en_on_low", obs(), 32'(E_LOW));

        // dead_time changed mid-count is ignored until the next load
        dead_time = 16'd2;
        pwm_in = 1'b1;
        tick(); chk("dtchg_load", obs(), 32'(E_DEAD));
        dead_time = 16'd9;
        tick(); chk("dtchg_dead", obs(), 32'(E_DEAD));
        tick(); chk("dtchg_high", obs(), 32'(E_HIGH));

        // Reset aborts a dead time in progress
        pwm_in = 1'b0;
        tick(); chk("rst_mid_dead", obs(), 32'(E_DEAD));
        reset = 1'b0;
        tick(); chk("rst_mid_idle", obs(), 32'(E_IDLE));
        reset = 1'b1;
        dead_time = 16'd1;
        tick(); chk("rst_mid_restart", obs(), 32'(E_DEAD));
        tick(); chk("rst_mid_low", obs(), 32'(E_LOW));

        // Random stimulus; overlap monitor covers both polarities
        for (int i = 0; i < 400; i++) begin
            pwm_in    = 1'($urandom_range(0, 1));
            enable    = ($urandom_range(0, 15) != 0);
            dead_time = 16'($urandom_range(0, 3));
            tick();
        end
        chk("overlap_pos", 32'(ov_pos), 32'd0);
        chk("overlap_neg", 32'(ov_neg), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
